// File: rtl/rom_port_arbiter_if.sv
// Bus bundle between core instr/data ports, the ROM macro and the arbiter.
// slave: arbiter view; master: core/ROM/environment view.
interface rom_port_arbiter_if;
  logic        instr_req;
  logic [31:0] instr_addr;
  logic        instr_gnt;
  logic        instr_rvalid;
  logic [31:0] instr_rdata;
  logic        data_req;
  logic        data_we;
  logic [31:0] data_addr;
  logic        data_gnt;
  logic        data_rvalid;
  logic [31:0] data_rdata;
  logic        data_err;
  logic        rom_cs;
  logic [31:0] rom_addr;
  logic [31:0] rom_rdata;

  modport slave (
    input  instr_req, instr_addr,
    output instr_gnt, instr_rvalid, instr_rdata,
    input  data_req, data_we, data_addr,
    output data_gnt, data_rvalid, data_rdata, data_err,
    output rom_cs, rom_addr,
    input  rom_rdata
  );

  modport master (
    output instr_req, instr_addr,
    input  instr_gnt, instr_rvalid, instr_rdata,
    output data_req, data_we, data_addr,
    input  data_gnt, data_rvalid, data_rdata, data_err,
    input  rom_cs, rom_addr,
    output rom_rdata
  );
endinterface

// File: rtl/rom_port_arbiter.sv
// Shares a single-port sync ROM between instr fetch and data load ports.
// Ports: HCLK, HRESETn (async low), bus (slave: instr/data OBI + ROM side).
// Param MAX_WAIT (1..15) bounds consecutive refused fetches under conflict.
// Macro ROM_ARB_RR_EN: round-robin on conflict instead of data priority.
module rom_port_arbiter #(
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic               HCLK,
  input  logic               HRESETn,
  rom_port_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    NONE,
    INSTR,
    DATA,
    DATA_ERR
  } owner_e;

  owner_e r_resp_owner;
  owner_e w_resp_owner_nxt;

  logic w_conflict;
  logic w_instr_win;
  logic w_instr_gnt;
  logic w_data_gnt;
  logic w_data_rd;

  assign w_conflict = bus.instr_req & bus.data_req;

`ifdef ROM_ARB_RR_EN
  // 1 = data was granted last; reset to "instr last" so data goes first.
  logic r_last_data;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_last_data <= 1'b0;
    end else if (w_instr_gnt | w_data_gnt) begin
      r_last_data <= w_data_gnt;
    end
  end

  assign w_instr_win = r_last_data;
`else
  localparam logic [3:0] LP_MAX_WAIT = 4'(MAX_WAIT);

  logic [3:0] r_wait_cnt;
  logic [3:0] w_wait_cnt_nxt;

  always_comb begin
    w_wait_cnt_nxt = '0;
    if (bus.instr_req && !w_instr_gnt) begin
      if (r_wait_cnt == LP_MAX_WAIT) begin
        w_wait_cnt_nxt = LP_MAX_WAIT;
      end else begin
        w_wait_cnt_nxt = r_wait_cnt + 4'd1;
      end
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_wait_cnt <= '0;
    end else begin
      r_wait_cnt <= w_wait_cnt_nxt;
    end
  end

  assign w_instr_win = (r_wait_cnt == LP_MAX_WAIT);
`endif

  // Grants are forced low while reset is held.
  always_comb begin
    w_instr_gnt = 1'b0;
    w_data_gnt  = 1'b0;
    if (HRESETn) begin
      unique case (1'b1)
        w_conflict: begin
          w_instr_gnt = w_instr_win;
          w_data_gnt  = ~w_instr_win;
        end
        bus.instr_req & ~bus.data_req: w_instr_gnt = 1'b1;
        bus.data_req & ~bus.instr_req: w_data_gnt  = 1'b1;
        default: ;
      endcase
    end
  end

  assign w_data_rd = w_data_gnt & ~bus.data_we;

  always_comb begin
    w_resp_owner_nxt = NONE;
    unique case (1'b1)
      w_instr_gnt:                 w_resp_owner_nxt = INSTR;
      w_data_gnt & bus.data_we:    w_resp_owner_nxt = DATA_ERR;
      w_data_rd:                   w_resp_owner_nxt = DATA;
      default: ;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_resp_owner <= NONE;
    end else begin
      r_resp_owner <= w_resp_owner_nxt;
    end
  end

  assign bus.instr_gnt = w_instr_gnt;
  assign bus.data_gnt  = w_data_gnt;

  // Idle address follows instr_addr to avoid needless ROM address toggling.
  assign bus.rom_cs   = w_instr_gnt | w_data_rd;
  assign bus.rom_addr = w_data_rd ? bus.data_addr : bus.instr_addr;

  assign bus.instr_rvalid = (r_resp_owner == INSTR);
  assign bus.instr_rdata  =
    (r_resp_owner == INSTR) ? bus.rom_rdata : '0;

  assign bus.data_rvalid =
    (r_resp_owner == DATA) | (r_resp_owner == DATA_ERR);
  assign bus.data_err   = (r_resp_owner == DATA_ERR);
  assign bus.data_rdata =
    (r_resp_owner == DATA) ? bus.rom_rdata : '0;

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Scoreboard bench for rom_port_arbiter with a behavioural 1-cycle ROM.
// Grants push expected responses; the monitor pops them a cycle later.
module tb_rom_port_arbiter;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } dexp_t;

  logic [31:0] iq[$];
  dexp_t       dq[$];

  rom_port_arbiter_if bus ();

  rom_port_arbiter #(.MAX_WAIT(4)) dut (
    .HCLK   (clk),
    .HRESETn(rst_n),
    .bus    (bus)
  );

  function automatic logic [31:0] romf(input logic [31:0] a);
    return {~a[15:0], a[15:0]} ^ 32'h5A5A_0000;
  endfunction

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.rom_cs) bus.rom_rdata <= romf(bus.rom_addr);
  end

  // Response monitor / scoreboard.
  always @(negedge clk) begin
    if (!rst_n) begin
      iq.delete();
      dq.delete();
      n_cmp++;
      if (bus.instr_rvalid !== 1'b0 || bus.data_rvalid !== 1'b0) begin
        n_err++;
        $display("FAIL rvalid_in_reset: got %b%b want 00",
                 bus.instr_rvalid, bus.data_rvalid);
      end
    end else begin
      n_cmp++;
      if (iq.size() > 0) begin
        logic [31:0] e;
        e = iq.pop_front();
        if (bus.instr_rvalid !== 1'b1 || bus.instr_rdata !== e) begin
          n_err++;
          $display("FAIL instr_resp: got v=%b %h want v=1 %h",
                   bus.instr_rvalid, bus.instr_rdata, e);
        end
      end else if (bus.instr_rvalid !== 1'b0 ||
                   bus.instr_rdata !== 32'h0) begin
        n_err++;
        $display("FAIL instr_idle: got v=%b %h want v=0 0",
                 bus.instr_rvalid, bus.instr_rdata);
      end
      n_cmp++;
      if (dq.size() > 0) begin
        dexp_t d;
        d = dq.pop_front();
        if (bus.data_rvalid !== 1'b1 || bus.data_rdata !== d.rdata ||
            bus.data_err !== d.err) begin
          n_err++;
          $display("FAIL data_resp: got v=%b e=%b %h want v=1 e=%b %h",
                   bus.data_rvalid, bus.data_err, bus.data_rdata,
                   d.err, d.rdata);
        end
      end else if (bus.data_rvalid !== 1'b0 || bus.data_err !== 1'b0 ||
                   bus.data_rdata !== 32'h0) begin
        n_err++;
        $display("FAIL data_idle: got v=%b e=%b %h want 0 0 0",
                 bus.data_rvalid, bus.data_err, bus.data_rdata);
      end
      n_cmp++;
      if ((bus.instr_gnt && (bus.data_gnt || !bus.instr_req)) ||
          (bus.data_gnt && !bus.data_req)) begin
        n_err++;
        $display("FAIL gnt_legal: got ig=%b dg=%b want legal grants",
                 bus.instr_gnt, bus.data_gnt);
      end
      if (bus.instr_gnt) begin
        n_cmp++;
        if (bus.rom_cs !== 1'b1 || bus.rom_addr !== bus.instr_addr) begin
          n_err++;
          $display("FAIL rom_instr: got cs=%b %h want cs=1 %h",
                   bus.rom_cs, bus.rom_addr, bus.instr_addr);
        end
        iq.push_back(romf(bus.instr_addr));
      end
      if (bus.data_gnt) begin
        n_cmp++;
        if (bus.data_we) begin
          if (bus.rom_cs !== 1'b0) begin
            n_err++;
            $display("FAIL rom_wr: got cs=%b want cs=0", bus.rom_cs);
          end
          dq.push_back('{rdata: 32'h0, err: 1'b1});
        end else begin
          if (bus.rom_cs !== 1'b1 || bus.rom_addr !== bus.data_addr) begin
            n_err++;
            $display("FAIL rom_data: got cs=%b %h want cs=1 %h",
                     bus.rom_cs, bus.rom_addr, bus.data_addr);
          end
          dq.push_back('{rdata: romf(bus.data_addr), err: 1'b0});
        end
      end
      if (!bus.instr_gnt && !bus.data_gnt) begin
        n_cmp++;
        if (bus.rom_cs !== 1'b0) begin
          n_err++;
          $display("FAIL rom_idle: got cs=%b want 0", bus.rom_cs);
        end
      end
    end
  end

  task automatic idle();
    bus.instr_req  = 1'b0;
    bus.data_req   = 1'b0;
    bus.data_we    = 1'b0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_pulse();
    cyc();
    idle();
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n          = 1'b0;
    bus.instr_req  = 1'b1;
    bus.instr_addr = 32'h10;
    bus.data_req   = 1'b1;
    bus.data_we    = 1'b0;
    bus.data_addr  = 32'h14;
    bus.rom_rdata  = 32'h0;
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if ({bus.instr_gnt, bus.data_gnt, bus.rom_cs, bus.instr_rvalid,
         bus.data_rvalid, bus.data_err} !== 6'b0 ||
        bus.instr_rdata !== 32'h0 || bus.data_rdata !== 32'h0) begin
      n_err++;
      $display("FAIL reset_outs: got %b%b%b%b%b%b want 000000",
               bus.instr_gnt, bus.data_gnt, bus.rom_cs,
               bus.instr_rvalid, bus.data_rvalid, bus.data_err);
    end
    cyc();
    idle();
    rst_n = 1'b1;
  endtask

  task automatic test_instr_only();
    for (int k = 0; k < 4; k++) begin
      cyc();
      bus.instr_req  = (k < 3);
      bus.instr_addr = 32'h100;
      @(negedge clk);
      n_cmp++;
      if (bus.instr_gnt !== (k < 3) || bus.rom_cs !== (k < 3)) begin
        n_err++;
        $display("FAIL instr_only_gnt[%0d]: got g=%b cs=%b want %b",
                 k, bus.instr_gnt, bus.rom_cs, k < 3);
      end
      if (k > 0) begin
        n_cmp++;
        if (bus.instr_rvalid !== 1'b1 ||
            bus.instr_rdata !== romf(32'h100)) begin
          n_err++;
          $display("FAIL instr_only_rv[%0d]: got %b %h want 1 %h",
                   k, bus.instr_rvalid, bus.instr_rdata, romf(32'h100));
        end
      end
    end
    idle();
  endtask

  task automatic test_dual();
    logic [31:0] ia;
    logic [31:0] da;
    logic        ei;
    reset_pulse();
    ia = 32'h200;
    da = 32'h300;
    for (int k = 0; k < 10; k++) begin
      if (k > 0) cyc();
      bus.instr_req  = 1'b1;
      bus.instr_addr = ia;
      bus.data_req   = 1'b1;
      bus.data_we    = 1'b0;
      bus.data_addr  = da;
`ifdef ROM_ARB_RR_EN
      ei = (k % 2 == 1);
`else
      ei = (k % 5 == 4);
`endif
      @(negedge clk);
      n_cmp++;
      if (bus.instr_gnt !== ei || bus.data_gnt !== !ei) begin
        n_err++;
        $display("FAIL dual_pattern[%0d]: got ig=%b dg=%b want %b %b",
                 k, bus.instr_gnt, bus.data_gnt, ei, !ei);
      end
      if (bus.instr_gnt) ia = ia + 32'h4;
      if (bus.data_gnt)  da = da + 32'h4;
    end
    cyc();
    idle();
  endtask

  task automatic test_data_write();
    cyc();
    bus.data_req  = 1'b1;
    bus.data_we   = 1'b1;
    bus.data_addr = 32'h20;
    @(negedge clk);
    n_cmp++;
    if (bus.data_gnt !== 1'b1 || bus.rom_cs !== 1'b0) begin
      n_err++;
      $display("FAIL wr_gnt: got g=%b cs=%b want 1 0",
               bus.data_gnt, bus.rom_cs);
    end
    cyc();
    idle();
    @(negedge clk);
    n_cmp++;
    if (bus.data_rvalid !== 1'b1 || bus.data_err !== 1'b1 ||
        bus.data_rdata !== 32'h0) begin
      n_err++;
      $display("FAIL wr_resp: got v=%b e=%b %h want 1 1 0",
               bus.data_rvalid, bus.data_err, bus.data_rdata);
    end
  endtask

  task automatic test_reset_mid();
    cyc();
    bus.instr_req  = 1'b1;
    bus.instr_addr = 32'h140;
    cyc();
    idle();
    n_cmp++;
    if (bus.instr_rvalid !== 1'b1) begin
      n_err++;
      $display("FAIL rst_mid_pre: got %b want 1", bus.instr_rvalid);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (bus.instr_rvalid !== 1'b0 || bus.instr_rdata !== 32'h0) begin
      n_err++;
      $display("FAIL rst_mid_drop: got %b %h want 0 0",
               bus.instr_rvalid, bus.instr_rdata);
    end
    cyc();
    rst_n = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      n_cmp++;
      if (bus.instr_rvalid !== 1'b0) begin
        n_err++;
        $display("FAIL rst_mid_replay[%0d]: got %b want 0",
                 k, bus.instr_rvalid);
      end
    end
  endtask

`ifndef ROM_ARB_RR_EN
  task automatic test_data_midstream();
    cyc();
    bus.instr_req  = 1'b1;
    bus.instr_addr = 32'h180;
    @(negedge clk);
    n_cmp++;
    if (bus.instr_gnt !== 1'b1) begin
      n_err++;
      $display("FAIL mid_first: got %b want 1", bus.instr_gnt);
    end
    for (int j = 1; j < 4; j++) begin
      cyc();
      bus.instr_addr = 32'h184;
      bus.data_req   = 1'b1;
      bus.data_we    = 1'b0;
      bus.data_addr  = 32'h400 + 32'(j * 4);
      @(negedge clk);
      n_cmp++;
      if (bus.data_gnt !== 1'b1 || bus.instr_gnt !== 1'b0 ||
          dut.r_wait_cnt !== 4'(j - 1)) begin
        n_err++;
        $display("FAIL mid_data[%0d]: got dg=%b ig=%b wc=%0d want 1 0 %0d",
                 j, bus.data_gnt, bus.instr_gnt, dut.r_wait_cnt, j - 1);
      end
    end
    cyc();
    idle();
  endtask
`endif

  task automatic test_back_to_back();
    for (int k = 0; k < 8; k++) begin
      if (k > 0) cyc();
      bus.instr_req  = (k % 2 == 0);
      bus.instr_addr = 32'h800 + 32'(k * 4);
      bus.data_req   = (k % 2 == 1);
      bus.data_we    = 1'b0;
      bus.data_addr  = 32'h900 + 32'(k * 8);
      @(negedge clk);
      n_cmp++;
      if (bus.instr_gnt !== (k % 2 == 0) ||
          bus.data_gnt !== (k % 2 == 1)) begin
        n_err++;
        $display("FAIL b2b[%0d]: got ig=%b dg=%b", k,
                 bus.instr_gnt, bus.data_gnt);
      end
    end
    cyc();
    idle();
    cyc();
    cyc();
    n_cmp++;
    if (iq.size() != 0 || dq.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d/%0d pending want 0/0",
               iq.size(), dq.size());
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_instr_only();
    test_dual();
    test_data_write();
    test_reset_mid();
`ifndef ROM_ARB_RR_EN
    test_data_midstream();
`endif
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/rom_port_arbiter.md
# rom_port_arbiter

Two-port arbiter that shares the single-port synchronous instruction ROM between the core instruction-fetch port and the core data port, so that constant tables linked into ROM can be read with data loads. It sits between the core's instr/data OBI-style interfaces and the `rom` macro. It owns the ROM `cs`/`addr` and routes the one-cycle-latency read data back to whichever port was granted. Arbitration is combinational within a cycle. A starvation counter bounds how long instruction fetch can wait.

## Interface
- `MAX_WAIT`, 4: maximum consecutive cycles `instr_req` may be refused while `data_req` is high; legal range 1..15.
- `HCLK` in 1: clock; all state updates on rising edge.
- `HRESETn` in 1: asynchronous active-low reset.
- `instr_req` in 1: fetch request.
- `instr_addr` in 32: fetch byte address.
- `instr_gnt` out 1: fetch accepted this cycle.
- `instr_rvalid` out 1: fetch data valid.
- `instr_rdata` out 32: fetch data; 0 when `instr_rvalid`=0.
- `data_req` in 1: data request.
- `data_we` in 1: data write strobe; ROM is read-only.
- `data_addr` in 32: data byte address.
- `data_gnt` out 1: data request accepted this cycle.
- `data_rvalid` out 1: data response valid.
- `data_rdata` out 32: data read value; 0 when `data_rvalid`=0 or on error.
- `data_err` out 1: qualifies `data_rvalid`; 1 = write attempted to ROM.
- `rom_cs` out 1: ROM chip select.
- `rom_addr` out 32: ROM address.
- `rom_rdata` in 32: ROM read data, valid the cycle after `rom_cs`.

## Operation
- Grant is combinational: at most one of `instr_gnt`/`data_gnt` is high per cycle. A grant is only ever given to a port whose req is high.
- Only one requester active: it is granted in the same cycle.
- Both requesters active, fixed priority (default): data wins unless `wait_cnt` == `MAX_WAIT`, in which case instr wins.
- `wait_cnt` behaviour:
  - Width 4 bits.
  - Increments when `instr_req`=1 and `instr_gnt`=0.
  - Clears when `instr_gnt`=1 or `instr_req`=0.
  - Saturates at `MAX_WAIT`.
- Data read granted (`data_we`=0): `rom_cs`=1, `rom_addr`=`data_addr`.
- Instr granted: `rom_cs`=1, `rom_addr`=`instr_addr`.
- Data write granted (`data_we`=1):
  - `data_gnt`=1, `rom_cs`=0, no ROM access.
  - Response next cycle: `data_rvalid`=1, `data_err`=1, `data_rdata`=0.
- No grant: `rom_cs`=0, `rom_addr`=`instr_addr` (don't-care, held stable for power).
- Response tracking:
  - Register `resp_owner` ∈ {NONE, INSTR, DATA, DATA_ERR}, loaded every cycle from that cycle's grant.
  - Outputs are decoded from `resp_owner`. Response routing is independent of the new requests present in the same cycle, so back-to-back grants are supported at full throughput.

## Timing
- Reset values: `resp_owner`=NONE and `wait_cnt`=0. All outputs are therefore 0: `*_rvalid`, `data_err`, `*_rdata`, `rom_cs`. The `*_gnt` outputs are also 0, since they are forced low while `HRESETn`=0.
- Latency: grant in cycle N → `rvalid` in cycle N+1, exactly one cycle; no backpressure on responses.
- Requesters must hold addr/we stable while req=1 and gnt=0. Req may drop without a grant; no state is retained for it.
- Reset asserted mid-transaction: the pending response is discarded immediately (asynchronously) and `rvalid` drops the same instant. Nothing is replayed after reset.
- Sustained dual request with `MAX_WAIT`=M, fixed priority: M data grants, then 1 instr grant, repeating. Instr therefore receives 1/(M+1) of the bandwidth.

## Configuration
- `ROM_ARB_RR_EN` defined:
  - Round-robin arbitration. A 1-bit `last_owner` register (reset = INSTR) is updated on every grant.
  - On conflict, the port not granted last wins. Sustained dual request alternates D,I,D,I starting with data.
  - `wait_cnt` is not implemented and `MAX_WAIT` is ignored.
- `ROM_ARB_RR_EN` undefined: fixed data priority with the starvation counter, as described in Operation.

## Test plan
- Instr only, `instr_addr`=0x100 for 3 cycles → `instr_gnt`=1 each cycle. `instr_rvalid`=1 in cycles 2–4 with ROM words at 0x100; `rom_cs` high for 3 cycles.
- Both req continuously, fixed priority, `MAX_WAIT`=4 → grant pattern D,D,D,D,I repeating. `instr_rdata` and `data_rdata` each match their own address every cycle.
- Data write to 0x20 → `data_gnt`=1, `rom_cs`=0. Next cycle: `data_rvalid`=1, `data_err`=1, `data_rdata`=0.
- `HRESETn` low in the cycle after an instr grant → `instr_rvalid` drops to 0 immediately. After release, no response appears until a new grant.
- With `ROM_ARB_RR_EN` defined, both req for 6 cycles → grants D,I,D,I,D,I; data responses `data_err`=0.
- Instr req alone, then data req rising mid-stream with `wait_cnt`=0 → data granted that cycle. `instr_gnt`=0, instr req held, and `wait_cnt` counts 1,2….
